// File: rtl/product_accumulator_pkg.sv
// Shared types and default constants for the product accumulator (mac_pkg).
// Optional build macro SATURATE_EN selects clamping instead of wrap-around.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_COUNT  = 8;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / frame-sum-out handshake bundle for product_accumulator.
// The master side feeds products and consumes sums; the slave side is the block.
interface product_accumulator_if #(
    parameter int PROD_W = mac_pkg::DEF_PROD_W,
    parameter int ACC_W  = mac_pkg::DEF_ACC_W
) ();
    import mac_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/product_accumulator_acc_add.sv
// Accumulator adder: ACC_W sum of the running total and a zero-extended product,
// with carry out. Under SATURATE_EN a carry clamps the sum to all ones.
module acc_add #(
    parameter int PROD_W = mac_pkg::DEF_PROD_W,
    parameter int ACC_W  = mac_pkg::DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);
    import mac_pkg::*;

    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_acc} + (ACC_W+1)'(i_prod);
    assign o_carry = w_full[ACC_W];

`ifdef SATURATE_EN
    // A clamped total plus any nonzero product carries again, so it stays clamped.
    assign o_sum = o_carry ? '1 : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of products into frames closed by in_last or COUNT beats and
// presents each frame sum on a registered handshake. Build macro: SATURATE_EN.
module product_accumulator #(
    parameter int PROD_W = mac_pkg::DEF_PROD_W,
    parameter int ACC_W  = mac_pkg::DEF_ACC_W,
    parameter int COUNT  = mac_pkg::DEF_COUNT
) (
    input logic clk,
    input logic rst,
    product_accumulator_if.slave bus
);
    import mac_pkg::*;

    localparam logic [CNT_W:0] COUNT_L = (CNT_W+1)'(COUNT);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_acc;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;
    logic [CNT_W:0]     w_cnt_nxt;
    logic               w_close;

    acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_prod  (bus.in_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    assign w_cnt_nxt = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    // Either closing condition ends the same single frame.
    assign w_close   = bus.in_last | (w_cnt_nxt == COUNT_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (w_close) begin
                            r_out_sum   <= w_sum;
                            r_out_count <= w_cnt_nxt[CNT_W-1:0];
                            r_out_ovf   <= r_ovf_acc | w_carry;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_ovf_acc   <= 1'b0;
                        end else begin
                            r_acc       <= w_sum;
                            r_cnt       <= w_cnt_nxt[CNT_W-1:0];
                            r_ovf_acc   <= r_ovf_acc | w_carry;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = !r_out_valid;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default instance, a narrow-accumulator
// overflow instance (ACC_W=20, COUNT=32) and a short-frame instance (COUNT=4).
module tb_product_accumulator;

    localparam int A = 65025;
`ifdef SATURATE_EN
    localparam int OVF_SUM = 1048575;
`else
    localparam int OVF_SUM = 56849;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(16), .ACC_W(24)) if0 ();
    product_accumulator_if #(.PROD_W(16), .ACC_W(20)) if1 ();
    product_accumulator_if #(.PROD_W(16), .ACC_W(24)) if2 ();

    product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(8))  u0 (.clk(clk), .rst(rst), .bus(if0));
    product_accumulator #(.PROD_W(16), .ACC_W(20), .COUNT(32)) u1 (.clk(clk), .rst(rst), .bus(if1));
    product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(4))  u2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        int          sel;
        bit          v;
        logic [15:0] prod;
        bit          last;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        bit          chk;
        logic [23:0] e_sum;
        logic [7:0]  e_cnt;
        bit          e_ovf;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(int sel, bit v, int p, bit l, bit r,
                                bit eir, bit eov, bit chk, int esum, int ecnt, bit eovf);
        vec_t t;
        t.sel = sel; t.v = v; t.prod = 16'(p); t.last = l; t.ordy = r;
        t.e_ir = eir; t.e_ov = eov; t.chk = chk;
        t.e_sum = 24'(esum); t.e_cnt = 8'(ecnt); t.e_ovf = eovf;
        tbl.push_back(t);
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic idle_all();
        if0.in_valid = 0; if0.in_prod = '0; if0.in_last = 0; if0.out_ready = 1;
        if1.in_valid = 0; if1.in_prod = '0; if1.in_last = 0; if1.out_ready = 1;
        if2.in_valid = 0; if2.in_prod = '0; if2.in_last = 0; if2.out_ready = 1;
    endtask

    task automatic drive(int sel, bit v, logic [15:0] p, bit l, bit r);
        idle_all();
        case (sel)
            0: begin if0.in_valid = v; if0.in_prod = p; if0.in_last = l; if0.out_ready = r; end
            1: begin if1.in_valid = v; if1.in_prod = p; if1.in_last = l; if1.out_ready = r; end
            default: begin if2.in_valid = v; if2.in_prod = p; if2.in_last = l; if2.out_ready = r; end
        endcase
    endtask

    task automatic sample(int sel, output bit ir, output bit ov, output logic [23:0] sum,
                          output logic [7:0] cnt, output bit ovf);
        case (sel)
            0: begin ir = if0.in_ready; ov = if0.out_valid; sum = if0.out_sum;
                     cnt = if0.out_count; ovf = if0.out_ovf; end
            1: begin ir = if1.in_ready; ov = if1.out_valid; sum = 24'(if1.out_sum);
                     cnt = if1.out_count; ovf = if1.out_ovf; end
            default: begin ir = if2.in_ready; ov = if2.out_valid; sum = if2.out_sum;
                     cnt = if2.out_count; ovf = if2.out_ovf; end
        endcase
    endtask

    task automatic check_all(int sel, int idx, bit eir, bit eov, bit chk,
                             int esum, int ecnt, bit eovf);
        bit ir, ov, ovf;
        logic [23:0] sum;
        logic [7:0]  cnt;
        sample(sel, ir, ov, sum, cnt, ovf);
        check("in_ready", idx, 32'(ir), 32'(eir));
        check("out_valid", idx, 32'(ov), 32'(eov));
        if (chk) begin
            check("out_sum", idx, 32'(sum), 32'(esum));
            check("out_count", idx, 32'(cnt), 32'(ecnt));
            check("out_ovf", idx, 32'(ovf), 32'(eovf));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // full frame on the default instance
        for (int k = 0; k < 7; k++) add(0, 1, A, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, A, 0, 1, 0, 1, 1, 520200, 8, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // early close, then a fresh frame starting from zero
        add(0, 1, 6, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 10, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 20, 1, 1, 0, 1, 1, 36, 3, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 2, 1, 1, 0, 1, 1, 3, 2, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // backpressure with input beats offered during HOLD
        add(0, 1, 7, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 8, 1, 0, 0, 1, 1, 15, 2, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 1000, 1, 0, 0, 1, 1, 15, 2, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 1, 4, 4, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // overflow on the 20-bit accumulator, then a clean 1-beat frame
        for (int k = 0; k < 16; k++) add(1, 1, A, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, A, 1, 1, 0, 1, 1, OVF_SUM, 17, 1);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 3, 1, 1, 0, 1, 1, 3, 1, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // COUNT=4: last and count limit on the same beat give one frame
        for (int k = 0; k < 3; k++) add(2, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
        add(2, 1, 5, 1, 0, 0, 1, 1, 20, 4, 0);
        add(2, 0, 0, 0, 0, 0, 1, 1, 20, 4, 0);
        add(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(2, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(2, 1, 1, 0, 1, 0, 1, 1, 4, 4, 0);
        add(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_all(0, -1, 1, 0, 1, 0, 0, 0);
        check_all(1, -1, 1, 0, 1, 0, 0, 0);
        check_all(2, -1, 1, 0, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].sel, tbl[i].v, tbl[i].prod, tbl[i].last, tbl[i].ordy);
            @(posedge clk);
            #1;
            check_all(tbl[i].sel, i, tbl[i].e_ir, tbl[i].e_ov, tbl[i].chk,
                      int'(tbl[i].e_sum), int'(tbl[i].e_cnt), tbl[i].e_ovf);
        end

        // asynchronous reset mid-frame on u0 while u2 holds an undelivered result
        idle_all();
        if2.in_valid = 1; if2.in_prod = 16'd9; if2.in_last = 1; if2.out_ready = 0;
        @(posedge clk); #1;
        if2.in_valid = 0; if2.in_last = 0;
        check("u2_hold_valid", 900, 32'(if2.out_valid), 32'd1);
        if0.in_valid = 1; if0.in_prod = 16'd100; if0.in_last = 0;
        repeat (3) @(posedge clk);
        #1 if0.in_valid = 0;
        check("u0_acc_before_rst", 901, 32'(u0.r_acc), 32'd300);
        #3 rst = 1'b1;
        #1;
        check("rst_u0_out_valid", 902, 32'(if0.out_valid), 32'd0);
        check("rst_u0_in_ready", 902, 32'(if0.in_ready), 32'd1);
        check("rst_u0_acc", 902, 32'(u0.r_acc), 32'd0);
        check("rst_u0_cnt", 902, 32'(u0.r_cnt), 32'd0);
        check("rst_u2_out_valid", 902, 32'(if2.out_valid), 32'd0);
        check("rst_u2_in_ready", 902, 32'(if2.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        if2.out_ready = 1;
        if0.in_valid = 1; if0.in_prod = 16'd1; if0.in_last = 0;
        repeat (8) @(posedge clk);
        #1 if0.in_valid = 0;
        check_all(0, 903, 0, 1, 1, 8, 8, 0);
        @(posedge clk); #1;
        check_all(0, 904, 1, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 8x8 unsigned multiplier. Consumes a stream of 16-bit products over a valid/ready handshake and sums them into frames.
- A frame closes after COUNT products, or earlier on in_last. The frame sum is then presented on a registered output with its own valid/ready handshake.
- Used as the accumulate half of a multiply-accumulate (dot-product) path.

Parameters:
- PROD_W, 16, product width; matches the multiplier output.
- ACC_W, 24, accumulator and out_sum width; must be ≥ PROD_W.
- COUNT, 8, products per full frame; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_prod  input  PROD_W  unsigned product (A*B).
- in_last  input  1  closes the frame early; qualified by the transfer.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  frame sum.
- out_count  output  8  number of beats in the frame (1..COUNT).
- out_ovf  output  1  sum exceeded 2^ACC_W-1 during the frame.

Behaviour:
- Reset, asynchronous, active-high:
  - state=ACCUM, acc=0, cnt=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - A partially accumulated frame is discarded. A pending output is dropped.
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready is a pure function of state: in_ready = !out_valid.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Per input transfer in ACCUM:
  - acc <= acc + zero-extended in_prod.
  - cnt <= cnt + 1.
  - ovf_acc sets if the add carries out of ACC_W.
- Frame end is a transfer with in_last=1 or cnt+1==COUNT. Both conditions in the same beat close exactly one frame.
- At frame end, in the same edge:
  - out_sum <= acc + in_prod.
  - out_count <= cnt + 1.
  - out_ovf <= ovf_acc | carry.
  - out_valid <= 1; state <= HOLD.
  - acc, cnt and ovf_acc clear to 0.
- Latency: out_valid asserts 1 cycle after the closing beat.
- HOLD:
  - out_sum, out_count and out_ovf are stable until the output transfer.
  - On the output transfer: out_valid <= 0 and state <= ACCUM. in_ready is high in the next cycle.
- Throughput: 1 beat per cycle inside a frame. Minimum 1 idle input cycle per frame; more if out_ready is held low.
- in_valid=0 in ACCUM: hold all state; no timeout.
- in_prod must not change while in_valid=1 and in_ready=0. In HOLD the input is ignored.
- Overflow default: wrap modulo 2^ACC_W; out_ovf still reports the wrap.

Optional Feature:
- Macro SATURATE_EN.
- Defined: once an add carries out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the frame. out_sum is then 2^ACC_W-1 and out_ovf=1.
- Undefined: wrap-around behaviour as described above. out_ovf is still driven.

Decomposition:
- Package mac_pkg holds:
  - state enum {ACCUM, HOLD};
  - default constants for PROD_W, ACC_W, COUNT;
  - the 8-bit frame-count width constant.
- One natural sub-module: acc_add. It is the ACC_W adder producing sum plus carry, with the clamp compiled in under SATURATE_EN.

Test Plan:
- Full frame, defaults: 8 beats of 65025 (255*255), out_ready=1. Expect out_sum=520200, out_count=8, out_ovf=0, out_valid exactly 1 cycle after beat 8, then in_ready=1.
- Early close: beats 6, 10 and 20 with in_last on the third. Expect out_sum=36, out_count=3. The next frame starts from acc=0.
- Backpressure: close a frame with out_ready=0 for 5 cycles. Expect in_ready=0 and out_sum stable for those 5 cycles. After out_ready=1, one output transfer occurs and in_valid beats during HOLD are not counted.
- Overflow, ACC_W=20 and COUNT=32: 17 beats of 65025 with in_last on beat 17.
  - Without SATURATE_EN: expect out_sum=56849, out_ovf=1.
  - With SATURATE_EN: expect out_sum=1048575, out_ovf=1.
- Reset mid-frame: 3 beats of 100, then rst asserted asynchronously between edges. Expect out_valid=0, in_ready=1 and acc cleared immediately. A following 8-beat frame of 1s gives out_sum=8.
- Simultaneous close: COUNT=4, in_last on beat 4 with value 5. Expect exactly one frame, out_count=4, no empty extra frame.
